// File: rtl/pc_fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package pc_fetch_stage_pkg;

  localparam int          XLEN_DEFAULT      = 64;
  localparam logic [63:0] RESET_PC_DEFAULT  = 64'h0;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  // Per-edge update selected for the PC and the IF/ID register, in priority order.
  typedef enum logic [1:0] {
    SEL_RESET    = 2'd0,
    SEL_REDIRECT = 2'd1,
    SEL_HOLD     = 2'd2,
    SEL_SEQ      = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory port: address out from fetch, same-cycle read data back.
interface pc_fetch_stage_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/pc_fetch_stage_pc_adder.sv
// XLEN-bit PC incrementer; carry out of the top bit is discarded so the PC wraps.
module pc_adder #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);
  assign pc_plus4 = pc + XLEN'(4);
endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, next-PC select (reset > redirect > stall > advance)
// and the IF/ID pipeline register fed from an async-read instruction memory.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  pc_fetch_stage_if.master imem,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic             misaligned
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  pc_sel_e         sel;

  pc_adder #(.XLEN(XLEN)) u_pc_adder (
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  // The memory address comes straight from the PC register, never from stall/redirect.
  assign imem.imem_addr = pc;

  always_comb begin
    // NOTE: sel gets a default before any branch so every path assigns it and no latch is inferred.
    sel = SEL_SEQ;
    if (reset)         sel = SEL_RESET;
    else if (redirect) sel = SEL_REDIRECT;
    else if (stall)    sel = SEL_HOLD;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    case (sel)
      SEL_RESET: begin
        pc          <= RESET_PC;
        if_id_pc    <= '0;
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
        misaligned  <= 1'b0;
      end
      SEL_REDIRECT: begin
        // Target low bits are dropped; the wrong-path fetch in IF/ID becomes a bubble.
        pc          <= {redirect_pc[XLEN-1:2], 2'b00};
        if_id_pc    <= '0;
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
        misaligned  <= |redirect_pc[1:0];
      end
      SEL_HOLD: begin
        misaligned  <= 1'b0;
      end
      default: begin
        pc          <= pc_plus4;
        if_id_pc    <= pc;
        if_id_instr <= imem.imem_rdata;
        if_id_valid <= 1'b1;
        misaligned  <= 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: reset, sequential fetch, stall, redirect,
// misaligned target, PC wrap and mid-run reset.
module tb_pc_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;

  pc_fetch_stage_if #(.XLEN(64)) imem_bus ();

  // Instruction memory: each word is a recognisable function of its address.
  function automatic logic [31:0] word_at(input logic [63:0] addr);
    return 32'h1000_0000 + addr[31:0];
  endfunction

  assign imem_bus.imem_rdata = word_at(imem_bus.imem_addr);

  pc_fetch_stage #(
    .XLEN      (64),
    .RESET_PC  (64'h0),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic expect_state(input string tag, input logic [63:0] e_pc, input logic [63:0] e_ipc,
                              input logic [31:0] e_instr, input logic e_valid, input logic e_mis);
    check({tag, ".imem_addr"},   imem_bus.imem_addr, e_pc);
    check({tag, ".if_id_pc"},    if_id_pc,           e_ipc);
    check({tag, ".if_id_instr"}, 64'(if_id_instr),   64'(e_instr));
    check({tag, ".if_id_valid"}, 64'(if_id_valid),   64'(e_valid));
    check({tag, ".misaligned"},  64'(misaligned),    64'(e_mis));
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset held two cycles, with redirect/stall asserted on the second edge.
    step();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h0000_0000_0000_0F03;
    step();
    expect_state("reset", 64'h0, 64'h0, NOP, 1'b0, 1'b0);

    // Sequential fetch: IF/ID lags the PC by one edge.
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step();
    expect_state("seq0", 64'h4, 64'h0, 32'h1000_0000, 1'b1, 1'b0);
    step();
    expect_state("seq1", 64'h8, 64'h4, 32'h1000_0004, 1'b1, 1'b0);

    // Stall three cycles at pc=8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_state($sformatf("stall%0d", i), 64'h8, 64'h4, 32'h1000_0004, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step();
    expect_state("unstall", 64'hC, 64'h8, 32'h1000_0008, 1'b1, 1'b0);

    // Redirect wins over a simultaneous stall.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h100;
    step();
    expect_state("redir", 64'h100, 64'h0, NOP, 1'b0, 1'b0);
    stall = 1'b0; redirect = 1'b0;
    step();
    expect_state("redir_next", 64'h104, 64'h100, 32'h1000_0100, 1'b1, 1'b0);

    // Misaligned target: aligned PC, one-cycle flag.
    redirect = 1'b1; redirect_pc = 64'h202;
    step();
    expect_state("mis", 64'h200, 64'h0, NOP, 1'b0, 1'b1);
    redirect = 1'b0;
    step();
    expect_state("mis_next", 64'h204, 64'h200, 32'h1000_0200, 1'b1, 1'b0);

    // Back-to-back redirects keep IF/ID a bubble.
    redirect = 1'b1; redirect_pc = 64'h300;
    step();
    expect_state("b2b0", 64'h300, 64'h0, NOP, 1'b0, 1'b0);
    redirect_pc = 64'h401;
    step();
    expect_state("b2b1", 64'h400, 64'h0, NOP, 1'b0, 1'b1);

    // Misaligned flag clears under a stall that follows the redirect.
    redirect_pc = 64'h503; stall = 1'b1;
    step();
    expect_state("mis_stall0", 64'h500, 64'h0, NOP, 1'b0, 1'b1);
    redirect = 1'b0;
    step();
    expect_state("mis_stall1", 64'h500, 64'h0, NOP, 1'b0, 1'b0);
    stall = 1'b0;

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    expect_state("wrap0", 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, NOP, 1'b0, 1'b0);
    redirect = 1'b0;
    step();
    expect_state("wrap1", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0FFF_FFFC, 1'b1, 1'b0);
    step();
    expect_state("wrap2", 64'h4, 64'h0, 32'h1000_0000, 1'b1, 1'b0);

    // Mid-run reset overrides a simultaneous misaligned redirect and stall.
    reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h801;
    step();
    expect_state("midreset", 64'h0, 64'h0, NOP, 1'b0, 1'b0);
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step();
    expect_state("post_reset", 64'h4, 64'h0, 32'h1000_0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
